// File: rtl/instr_prefetch_if.sv
// Bundles the fetch-request/response channel toward instruction memory and
// the {pc, instr} output channel toward the IF/ID register.
interface instr_prefetch_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_instr;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  // Prefetch unit side.
  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_instr,
    output out_valid, out_pc, out_instr,
    input  out_ready
  );

  // Memory / decode side.
  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_instr,
    input  out_valid, out_pc, out_instr,
    output out_ready
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: issues sequential fetches to a variable-latency
// memory under a credit limit of DEPTH, queues in-order responses, presents
// one {pc, instr} per cycle to decode, and discards stale fetches on redirect.
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  instr_prefetch_if.master bus
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;

  logic          req_fire;
  logic          resp_take;
  logic          push;
  logic          pop;
  logic [CW-1:0] inflight_nxt;
  logic [31:0]   redirect_word;
  logic          unused_pc_bits;

  assign redirect_word  = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Handshake outputs, queue head presentation and per-cycle event decode.
  always_comb begin
    // Requests only while out of reset, not redirecting, and with a free credit.
    bus.mem_req_valid = rst && !redirect &&
                        (({1'b0, count} + {1'b0, inflight}) < DEPTH_W);
    bus.mem_req_addr  = fetch_pc;
    bus.out_valid     = (count != '0) && !redirect;
    bus.out_pc        = (count != '0) ? q_pc[rd_ptr]    : 32'h0;
    bus.out_instr     = (count != '0) ? q_instr[rd_ptr] : NOP;

    req_fire     = bus.mem_req_valid && bus.mem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_take    = bus.mem_resp_valid && ((inflight != '0) || (drop != '0));
    push         = resp_take && (drop == '0) && !redirect;
    pop          = bus.out_valid && bus.out_ready;
    inflight_nxt = inflight + CW'(req_fire) - CW'(resp_take);
  end

  // Control state: fetch/response PCs, queue pointers and credit counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      inflight <= inflight_nxt;
      if (redirect) begin
        fetch_pc <= redirect_word;
        resp_pc  <= redirect_word;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // Every fetch still outstanding after this edge belongs to the
        // abandoned stream, so all of them must be discarded on return.
        drop     <= inflight_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (resp_take) begin
          if (drop != '0) drop <= drop - CW'(1);
          else            resp_pc <= resp_pc + 32'd4;
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage written on push.
  // NOTE: entry storage has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= resp_pc;
      q_instr[wr_ptr] <= bus.mem_resp_instr;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: a transaction-level model (queues of
// outstanding fetches and buffered entries) predicts every output each cycle,
// with directed scenarios pinned by literal expectations and a random phase.
module tb_instr_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;

  instr_prefetch_if bus();

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: accepted requests waiting for their response cycle.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];

  // Reference model: outstanding fetches (stale after a redirect) and queued entries.
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  fl_t         m_fl[$];
  ent_t        m_q[$];
  logic [31:0] m_fetch_pc = RESET_PC;

  logic [31:0] pops[$];
  logic [31:0] req_log[$];

  int          cyc = 0;
  int          mem_lat = 1;
  bit          resp_real;
  bit          d_rst, d_redirect, d_out_ready, d_req_ready, d_spur;
  logic [31:0] d_redirect_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return (i < pops.size()) ? pops[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare DUT outputs with the model, then advance model and memory by one edge.
  task automatic compare_and_update();
    bit          e_req_v, e_out_v;
    logic [31:0] e_pc, e_instr;
    fl_t         f;
    if (!rst) begin
      m_q.delete(); m_fl.delete(); mem_q.delete(); req_log.delete();
      m_fetch_pc = RESET_PC;
    end
    e_req_v = rst && !redirect && ((m_q.size() + m_fl.size()) < DEPTH);
    e_out_v = (m_q.size() > 0) && !redirect;
    e_pc    = (m_q.size() > 0) ? m_q[0].pc    : 32'h0;
    e_instr = (m_q.size() > 0) ? m_q[0].instr : NOP;
    check("mem_req_valid", 32'(bus.mem_req_valid), 32'(e_req_v));
    check("mem_req_addr",  bus.mem_req_addr, m_fetch_pc);
    check("out_valid",     32'(bus.out_valid), 32'(e_out_v));
    check("out_pc",        bus.out_pc, e_pc);
    check("out_instr",     bus.out_instr, e_instr);
    if (rst) begin
      if (bus.out_valid && bus.out_ready) pops.push_back(bus.out_pc);
      if (resp_real) void'(mem_q.pop_front());
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        mem_q.push_back('{bus.mem_req_addr, cyc + mem_lat});
        req_log.push_back(bus.mem_req_addr);
      end
      if (e_out_v && bus.out_ready) void'(m_q.pop_front());
      if (bus.mem_resp_valid && (m_fl.size() > 0)) begin
        f = m_fl.pop_front();
        if (!redirect && !f.stale) m_q.push_back('{f.pc, instr_of(f.pc)});
      end
      if (redirect) begin
        m_q.delete();
        foreach (m_fl[i]) m_fl[i].stale = 1'b1;
        m_fetch_pc = {redirect_pc[31:2], 2'b00};
      end else if (e_req_v && bus.mem_req_ready) begin
        m_fl.push_back('{m_fetch_pc, 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    rst               = d_rst;
    redirect          = d_redirect;
    redirect_pc       = d_redirect_pc;
    bus.out_ready     = d_out_ready;
    bus.mem_req_ready = d_req_ready;
    resp_real = d_rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    if (resp_real) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_instr = instr_of(mem_q[0].addr);
    end else if (d_rst && d_spur && (mem_q.size() == 0)) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_instr = $urandom;
    end else begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_instr = $urandom;
    end
    @(negedge clk);
    compare_and_update();
  endtask

  task automatic reset_dut();
    d_rst = 1'b0;
    d_redirect = 1'b0;
    step();
    step();
    d_rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.out_ready = 1'b0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_instr = '0;
    d_rst = 1'b0; d_redirect = 1'b0; d_redirect_pc = '0;
    d_out_ready = 1'b1; d_req_ready = 1'b1; d_spur = 1'b0;

    // Reset release with 1-cycle memory and a free-running consumer.
    mem_lat = 1;
    reset_dut();
    check("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
    check("rst_req_addr",  bus.mem_req_addr, 32'h0);
    check("rst_out_pc",    bus.out_pc, 32'h0);
    check("rst_out_instr", bus.out_instr, 32'h0000_0013);
    pops.delete();
    step();
    check("first_req_valid", 32'(bus.mem_req_valid), 32'h1);
    check("first_req_addr",  bus.mem_req_addr, 32'h0);
    step();
    check("c1_req_addr",  bus.mem_req_addr, 32'h4);
    check("c1_out_valid", 32'(bus.out_valid), 32'h0);
    step();
    check("c2_out_valid", 32'(bus.out_valid), 32'h1);
    check("c2_out_pc",    bus.out_pc, 32'h0);
    check("c2_out_instr", bus.out_instr, 32'h1357_9BDF);
    step();
    check("c3_out_pc", bus.out_pc, 32'h4);
    repeat (4) step();
    check("thru_pops", 32'(pops.size()), 32'd6);
    check("thru_pop5", pop_at(5), 32'h14);

    // Consumer stalled: exactly DEPTH requests, then ordered drain and resume.
    d_out_ready = 1'b0;
    reset_dut();
    repeat (10) step();
    check("stall_reqs",      32'(req_log.size()), 32'd4);
    check("stall_req_valid", 32'(bus.mem_req_valid), 32'h0);
    d_out_ready = 1'b1;
    pops.delete();
    step();
    check("drain_out_pc",    bus.out_pc, 32'h0);
    check("drain_req_valid", 32'(bus.mem_req_valid), 32'h0);
    repeat (7) step();
    for (int i = 0; i < 4; i++) check("drain_order", pop_at(i), 32'(4 * i));
    check("resume_addr", req_at(4), 32'h10);

    // Redirect with 2 queued entries and 2 fetches in flight.
    d_out_ready = 1'b0;
    reset_dut();
    mem_lat = 1;
    step(); step();
    mem_lat = 6;
    step(); step();
    pops.delete();
    mem_lat = 1;
    d_out_ready = 1'b1;
    d_redirect = 1'b1; d_redirect_pc = 32'h100;
    step();
    check("redir_out_valid", 32'(bus.out_valid), 32'h0);
    check("redir_req_valid", 32'(bus.mem_req_valid), 32'h0);
    d_redirect = 1'b0;
    repeat (16) step();
    check("redir_pop0", pop_at(0), 32'h100);
    check("redir_pop1", pop_at(1), 32'h104);

    // Redirect coinciding with a response in a steady stream.
    mem_lat = 2;
    reset_dut();
    repeat (6) step();
    pops.delete();
    d_redirect = 1'b1; d_redirect_pc = 32'h200;
    step();
    check("coinc_out_valid", 32'(bus.out_valid), 32'h0);
    d_redirect = 1'b0;
    repeat (10) step();
    check("coinc_pop0", pop_at(0), 32'h200);
    check("coinc_pop1", pop_at(1), 32'h204);

    // Address wrap; low redirect bits are ignored.
    pops.delete();
    d_redirect = 1'b1; d_redirect_pc = 32'hFFFF_FFFB;
    step();
    d_redirect = 1'b0;
    repeat (10) step();
    check("wrap_pop0", pop_at(0), 32'hFFFF_FFF8);
    check("wrap_pop1", pop_at(1), 32'hFFFF_FFFC);
    check("wrap_pop2", pop_at(2), 32'h0000_0000);

    // Back-to-back redirects: the last target wins.
    pops.delete();
    d_redirect = 1'b1; d_redirect_pc = 32'h300;
    step();
    d_redirect_pc = 32'h400;
    step();
    d_redirect = 1'b0;
    repeat (10) step();
    check("b2b_pop0", pop_at(0), 32'h400);
    check("b2b_pop1", pop_at(1), 32'h404);

    // Random traffic: stalls, latency 1..4, redirects, spurious responses, resets.
    for (int i = 0; i < 3000; i++) begin
      d_out_ready   = ($urandom_range(9) < 7);
      d_req_ready   = ($urandom_range(9) < 6);
      mem_lat       = 1 + $urandom_range(3);
      d_redirect    = ($urandom_range(99) < 3);
      d_redirect_pc = $urandom;
      d_spur        = ($urandom_range(99) < 5);
      d_rst         = !($urandom_range(999) < 2);
      step();
    end
    d_rst = 1'b1;
    d_redirect = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
